pool2x2_stream_ctrl: RTL and testbench



---
 rtl/pool2x2_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pool2x2_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_stream_ctrl.sv
// -----------------------------------------------------------------------------
// pool2x2_stream_ctrl
//
// Streaming 2x2 / stride-2 pooling controller. It takes a row-major raster of
// signed fixed-point pixels, one per beat, and produces one pooled pixel per
// 2x2 window. The reduction is signed max or floor average, selected per frame.
//
// Even input rows: each horizontal pixel pair is reduced and parked in a
// half-width row buffer. Odd input rows: each pair is reduced again and
// combined with the parked value to finish the window.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous reset, active-high
//   i_mode        0 = max, 1 = average; sampled on the first pixel of a frame
//   i_data        signed input pixel (DW bits)
//   i_valid       i_data valid
//   o_ready       input can be accepted this cycle (combinational from i_ready)
//   o_data        pooled pixel, signed (DW bits), held while stalled
//   o_valid       o_data valid
//   i_ready       downstream accepts o_data
//   o_frame_done  one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module pool2x2_stream_ctrl #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int IMG_W            = 512,
  parameter int IMG_H            = 512,
  localparam int DW              = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_mode,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_frame_done
);

  localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ROW_EVEN, ROW_ODD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 mode_q, mode_d;
  logic signed [DW-1:0] hold_q, hold_d;
  logic signed [DW-1:0] o_data_q, o_data_d;
  logic                 o_valid_q, o_valid_d;
  logic                 frame_done_q, frame_done_d;

  // Row buffer: one reduced horizontal pair per entry, one bit wider than a
  // pixel so an average-mode pair sum never overflows.
  logic signed [DW:0]   buf_mem [DEPTH];
  logic signed [DW:0]   buf_rd_q;
  logic                 buf_we, buf_re;
  logic [AW-1:0]        buf_addr;

  logic                 accept;
  logic signed [DW:0]   pair;
  logic signed [DW:0]   win_max;
  logic signed [DW+1:0] win_sum;

  // Reduce two pixels: signed max (sign-extended) or full-precision sum.
  function automatic logic signed [DW:0] reduce2(input logic m,
                                                 input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    if (m) return {a[DW-1], a} + {b[DW-1], b};
    else   return (a > b) ? {a[DW-1], a} : {b[DW-1], b};
  endfunction

  assign o_ready      = !o_valid_q || i_ready;
  assign accept       = i_valid && o_ready;
  assign o_data       = o_data_q;
  assign o_valid      = o_valid_q;
  assign o_frame_done = frame_done_q;

  // Both columns of a pair share one buffer entry.
  assign buf_addr = AW'(col_q >> 1);
  assign pair     = reduce2(mode_q, hold_q, i_data);
  assign win_max  = (pair > buf_rd_q) ? pair : buf_rd_q;
  assign win_sum  = {pair[DW], pair} + {buf_rd_q[DW], buf_rd_q};

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    hold_d       = hold_q;
    o_data_d     = o_data_q;
    o_valid_d    = o_valid_q;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;
    buf_re       = 1'b0;

    if (o_valid_q && i_ready) o_valid_d = 1'b0;

    if (accept) begin
      if (!col_q[0]) begin
        hold_d = i_data;
        // Fetch the parked even-row pair now so it is registered by the time
        // the odd-column partner arrives.
        if (state_q == ROW_ODD) buf_re = 1'b1;
        if (row_q == '0 && col_q == '0) mode_d = i_mode;
      end else if (state_q == ROW_EVEN) begin
        buf_we = 1'b1;
      end else begin
        // A new window load takes priority over a same-cycle drain.
        o_valid_d = 1'b1;
        o_data_d  = mode_q ? DW'(win_sum >>> 2) : DW'(win_max);
      end

      if (col_q == CW'(IMG_W - 1)) begin
        col_d   = '0;
        state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        if (row_q == RW'(IMG_H - 1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ROW_EVEN;
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      hold_q       <= '0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      hold_q       <= hold_d;
      o_data_q     <= o_data_d;
      o_valid_q    <= o_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer contents are never reset: every entry is written on an even row
  // before the following odd row reads it.
  always_ff @(posedge i_clk) begin
    if (buf_we) buf_mem[buf_addr] <= pair;
    if (buf_re) buf_rd_q <= buf_mem[buf_addr];
  end

endmodule

// File: tb/tb_pool2x2_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pool2x2_stream_ctrl
//
// Directed bench for pool2x2_stream_ctrl on a 4x4 image with DW = 13. Expected
// pooled values are computed by hand from the input tables below.
// -----------------------------------------------------------------------------
module tb_pool2x2_stream_ctrl;

  localparam int DW = 13;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_mode;
  logic signed [DW-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic signed [DW-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_frame_done;

  always #5 i_clk = ~i_clk;

  pool2x2_stream_ctrl #(
    .INTEGER_BITS    (9),
    .FIXED_POINT_BITS(4),
    .IMG_W           (4),
    .IMG_H           (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mode      (i_mode),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_done(o_frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Written only by the monitor process.
  int outq[$];
  int fd_cnt   = 0;
  int fd_data  = 0;
  int fd_valid = 0;

  // Read-side bookkeeping, owned by the main process.
  int rd_idx  = 0;
  int fd_base = 0;

  int ramp[16];
  int win3[16] = '{-1, -2, 4095, 4095, -3, -4, 4095, 4095,
                   0, 1, 2, 3, 4, 5, 6, 7};

  // Monitor: sample mid-cycle, log each completed output transfer.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_valid && i_ready) begin
          outq.push_back(int'(o_data));
          $display("[TB] out %0d", int'(o_data));
        end
        if (o_frame_done) begin
          fd_cnt   = fd_cnt + 1;
          fd_data  = int'(o_data);
          fd_valid = int'(o_valid);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one pixel and hold it until it is accepted.
  task automatic send(input int d, input logic m);
    int   waited;
    logic ok;
    waited  = 0;
    i_valid = 1'b1;
    i_mode  = m;
    i_data  = DW'(d);
    forever begin
      @(negedge i_clk);
      ok = o_ready;
      @(posedge i_clk);
      if (ok) break;
      waited++;
      if (waited > 200) begin
        check_eq("send_timeout", waited, 0);
        break;
      end
    end
    #1;
  endtask

  task automatic send_frame(input int px[16], input logic m_first, input logic m_rest);
    for (int i = 0; i < 16; i++) send(px[i], (i == 0) ? m_first : m_rest);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    repeat (6) @(posedge i_clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int exp);
    int got;
    got = (rd_idx < outq.size()) ? outq[rd_idx] : -100000;
    rd_idx++;
    check_eq(tag, got, exp);
  endtask

  task automatic expect4(input string tag, input int e0, input int e1,
                         input int e2, input int e3);
    expect_out(tag, e0);
    expect_out(tag, e1);
    expect_out(tag, e2);
    expect_out(tag, e3);
  endtask

  task automatic expect_done(input string tag, input int n, input int last);
    check_eq({tag, "_done_cnt"}, fd_cnt - fd_base, n);
    check_eq({tag, "_done_data"}, fd_data, last);
    check_eq({tag, "_done_valid"}, fd_valid, 1);
    fd_base = fd_cnt;
  endtask

  // Holds i_ready low for 10 cycles once the first output appears.
  task automatic stall_after_first();
    int waited;
    int held;
    waited = 0;
    while (!o_valid && waited < 300) begin
      @(posedge i_clk);
      #1;
      waited++;
    end
    check_eq("bp_wait_valid", int'(o_valid), 1);
    i_ready = 1'b0;
    held    = int'(o_data);
    repeat (10) begin
      @(negedge i_clk);
      check_eq("bp_hold_data", int'(o_data), held);
      check_eq("bp_ready_low", int'(o_ready), 0);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ramp[i] = i;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_mode  = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("rst_o_valid", int'(o_valid), 0);
    check_eq("rst_o_data", int'(o_data), 0);
    check_eq("rst_frame_done", int'(o_frame_done), 0);
    check_eq("rst_o_ready", int'(o_ready), 1);
    @(posedge i_clk);
    #1;

    // Max pooling over a ramp.
    fd_base = fd_cnt;
    send_frame(ramp, 1'b0, 1'b0);
    drain();
    expect4("max_ramp", 5, 7, 13, 15);
    expect_done("max_ramp", 1, 15);

    // Average pooling over the same ramp.
    send_frame(ramp, 1'b1, 1'b1);
    drain();
    expect4("avg_ramp", 2, 4, 10, 12);
    expect_done("avg_ramp", 1, 12);

    // Negative window and positive full-scale window.
    send_frame(win3, 1'b0, 1'b0);
    drain();
    expect4("max_neg", -1, 4095, 5, 7);
    expect_done("max_neg", 1, 7);
    send_frame(win3, 1'b1, 1'b1);
    drain();
    expect4("avg_neg", -3, 4095, 2, 4);
    expect_done("avg_neg", 1, 4);

    // Downstream backpressure right after the first output.
    fork
      send_frame(ramp, 1'b0, 1'b0);
      stall_after_first();
    join
    drain();
    expect4("bp_seq", 5, 7, 13, 15);
    expect_done("bp_seq", 1, 15);

    // Mode changes after the first pixel are ignored.
    send_frame(ramp, 1'b0, 1'b1);
    drain();
    expect4("mode_latch", 5, 7, 13, 15);
    expect_done("mode_latch", 1, 15);

    // Two frames with no gap: max then average.
    send_frame(ramp, 1'b0, 1'b0);
    send_frame(ramp, 1'b1, 1'b1);
    drain();
    expect4("b2b_max", 5, 7, 13, 15);
    expect4("b2b_avg", 2, 4, 10, 12);
    expect_done("b2b", 2, 12);

    // Reset in the middle of a frame with an output pending.
    for (int i = 0; i < 6; i++) send(ramp[i], 1'b0);
    i_valid = 1'b0;
    check_eq("pre_rst_valid", int'(o_valid), 1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_eq("post_rst_valid", int'(o_valid), 0);
    check_eq("post_rst_done", int'(o_frame_done), 0);
    check_eq("post_rst_ready", int'(o_ready), 1);
    rd_idx  = outq.size();
    fd_base = fd_cnt;
    send_frame(ramp, 1'b0, 1'b0);
    drain();
    expect4("after_rst", 5, 7, 13, 15);
    expect_done("after_rst", 1, 15);
    check_eq("no_extra_outputs", outq.size(), rd_idx);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
